t05_instr_fetch: RTL

- Instruction-fetch sequencer between the program counter and the instruction memory bus.
- Samples the current PC value, issues a single-word read on a req/ack memory interface, and holds the returned instruction for the decoder until it is accepted.
- Drives `pc_stall` back into the PC's Disable input, so the PC advances exactly once per accepted instruction.

---
 rtl/t05_instr_fetch.sv | 138 +++++++++++++
 1 files changed

// File: rtl/t05_instr_fetch.sv
// t05_instr_fetch: instruction-fetch sequencer between the PC and a
// req/ack instruction memory bus. Holds each fetched word for the
// decoder and stalls the PC until the word is accepted.
// Optional feature macro: T05_FETCH_TIMEOUT_EN (REQ-state timeout that
// substitutes NOP_INSTR with fetch_err set).
//
// state | meaning
// IDLE  | waiting for fetch_en; samples pc_val
// REQ   | read request on the bus, waiting for mem_ack
// VALID | instruction held for the decoder until accept or flush

module t05_instr_fetch #(
  parameter int          ADDR_W         = 32,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] pc_val,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic              dec_ready,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              fetch_err,
  output logic              pc_stall
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, VALID = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              drop_q;
  logic              misaligned;
  logic              timeout;

  assign misaligned = (pc_val[1:0] != 2'b00);

`ifdef T05_FETCH_TIMEOUT_EN
  logic [7:0] to_cnt;

  // timeout counter: cleared on REQ entry, counts REQ cycles without ack
  always_ff @(posedge clk) begin
    if (clr) begin
      to_cnt <= 8'd0;
    end else if (state == IDLE) begin
      to_cnt <= 8'd0;
    end else if (state == REQ && !mem_ack) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  assign timeout = (state == REQ) && !mem_ack && (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fetch_en) state_nxt = misaligned ? VALID : REQ;
      end
      REQ: begin
        if (mem_ack || timeout) state_nxt = (drop_q || flush) ? IDLE : VALID;
      end
      VALID: begin
        if (flush || dec_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // output decode from state and captured address
  always_comb begin
    mem_read    = (state == REQ);
    mem_addr    = addr_q;
    instr_valid = (state == VALID);
    pc_stall    = !((state == VALID) && dec_ready && !flush);
  end

  // datapath registers: address, held instruction, drop and error flags
  always_ff @(posedge clk) begin
    if (clr) begin
      addr_q    <= '0;
      instr     <= 32'd0;
      instr_pc  <= '0;
      drop_q    <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            addr_q <= pc_val;
            if (misaligned) begin
              instr     <= NOP_INSTR;
              instr_pc  <= pc_val;
              fetch_err <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            drop_q <= 1'b0;
            if (!drop_q && !flush) begin
              instr     <= mem_rdata;
              instr_pc  <= addr_q;
              fetch_err <= 1'b0;
            end
          end else if (timeout) begin
            drop_q <= 1'b0;
            if (!drop_q && !flush) begin
              instr     <= NOP_INSTR;
              instr_pc  <= addr_q;
              fetch_err <= 1'b1;
            end
          end else if (flush) begin
            drop_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
